// File: rtl/priority_encoder_stream_if.sv
// rtl/priority_encoder_stream_if.sv - request word in / one-hot beat out handshake bundle
// Optional cnt_o member present when PRIORITY_ENCODER_STREAM_CNT_EN is defined.
interface priority_encoder_stream_if #(
  parameter int WIDTH = 16
);
  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] data_i;
  logic             dir_i;
  logic             data_val_i;
  logic             data_ready_o;
  logic [WIDTH-1:0] onehot_o;
  logic [IDX_W-1:0] idx_o;
  logic             empty_o;
  logic             last_o;
  logic             out_val_o;
  logic             out_ready_i;
`ifdef PRIORITY_ENCODER_STREAM_CNT_EN
  logic [IDX_W:0]   cnt_o;
`endif

  modport master (
    output data_i, dir_i, data_val_i, out_ready_i,
    input  data_ready_o, onehot_o, idx_o, empty_o, last_o, out_val_o
`ifdef PRIORITY_ENCODER_STREAM_CNT_EN
    , input cnt_o
`endif
  );

  modport slave (
    input  data_i, dir_i, data_val_i, out_ready_i,
    output data_ready_o, onehot_o, idx_o, empty_o, last_o, out_val_o
`ifdef PRIORITY_ENCODER_STREAM_CNT_EN
    , output cnt_o
`endif
  );
endinterface

// File: rtl/priority_encoder_stream.sv
// rtl/priority_encoder_stream.sv - streams each set bit of a word as a one-hot/index beat
// Define PRIORITY_ENCODER_STREAM_CNT_EN to add the remaining-bit counter cnt_o.
module priority_encoder_stream #(
  parameter int WIDTH = 16
) (
  input logic                     clk_i,
  input logic                     arst_n_i,
  priority_encoder_stream_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_st;
  logic [WIDTH-1:0] r_residue;
  logic             r_dir;

  logic [IDX_W-1:0] w_lo_idx;
  logic [IDX_W-1:0] w_hi_idx;
  logic [IDX_W-1:0] w_idx;
  logic [WIDTH-1:0] w_onehot;
  logic             w_last;
  logic             w_busy;
  logic             w_in_fire;
  logic             w_out_fire;

  // Both scans run in parallel; the last match wins, so the descending loop finds the lowest bit.
  always_comb begin
    w_lo_idx = '0;
    w_hi_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (r_residue[i]) w_lo_idx = IDX_W'(i);
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (r_residue[i]) w_hi_idx = IDX_W'(i);
    end
    w_idx    = r_dir ? w_hi_idx : w_lo_idx;
    w_onehot = '0;
    if (r_residue != '0) w_onehot[w_idx] = 1'b1;
  end

  assign w_last     = (r_residue & (r_residue - WIDTH'(1))) == '0;
  assign w_busy     = (r_st == BUSY);
  assign w_out_fire = w_busy && bus.out_ready_i;
  assign w_in_fire  = bus.data_val_i && bus.data_ready_o;

  assign bus.out_val_o    = w_busy;
  assign bus.onehot_o     = w_busy ? w_onehot : '0;
  assign bus.idx_o        = w_busy ? w_idx : '0;
  assign bus.last_o       = w_busy && w_last;
  assign bus.empty_o      = w_busy && (r_residue == '0);
  assign bus.data_ready_o = !w_busy || (w_out_fire && w_last);

`ifdef PRIORITY_ENCODER_STREAM_CNT_EN
  localparam int CNT_W = IDX_W + 1;
  logic [CNT_W-1:0] w_pop;
  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + CNT_W'(bus.data_i[i]);
    end
  end

  assign bus.cnt_o = r_cnt;
`endif

  // An accept while busy can only coincide with the last beat, so it takes priority over the drain.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_st      <= IDLE;
      r_residue <= '0;
      r_dir     <= 1'b0;
`ifdef PRIORITY_ENCODER_STREAM_CNT_EN
      r_cnt     <= '0;
`endif
    end else if (w_in_fire) begin
      r_st      <= BUSY;
      r_residue <= bus.data_i;
      r_dir     <= bus.dir_i;
`ifdef PRIORITY_ENCODER_STREAM_CNT_EN
      r_cnt     <= w_pop;
`endif
    end else if (w_out_fire) begin
      if (!w_last) begin
        r_residue <= r_residue & ~w_onehot;
`ifdef PRIORITY_ENCODER_STREAM_CNT_EN
        r_cnt     <= r_cnt - CNT_W'(1);
`endif
      end else begin
        r_st      <= IDLE;
        r_residue <= '0;
`ifdef PRIORITY_ENCODER_STREAM_CNT_EN
        r_cnt     <= '0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_priority_encoder_stream.sv
// tb/tb_priority_encoder_stream.sv - directed checks of priority_encoder_stream beats and handshake
// Exercises cnt_o too when PRIORITY_ENCODER_STREAM_CNT_EN is defined.
module tb_priority_encoder_stream;
  logic clk;
  logic arst_n;
  int   n_pass;
  int   n_total;

  priority_encoder_stream_if #(.WIDTH(16)) bus ();

  priority_encoder_stream #(.WIDTH(16)) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input int idx, input logic lst, input logic rdy);
    logic [15:0] oh;
    oh = 16'd1 << idx;
    chk({tag, ".val"},    bus.out_val_o,    1);
    chk({tag, ".onehot"}, bus.onehot_o,     oh);
    chk({tag, ".idx"},    bus.idx_o,        idx);
    chk({tag, ".last"},   bus.last_o,       lst);
    chk({tag, ".empty"},  bus.empty_o,      0);
    chk({tag, ".ready"},  bus.data_ready_o, rdy);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    arst_n = 1'b0;
    bus.data_i = '0;
    bus.dir_i = 1'b0;
    bus.data_val_i = 1'b0;
    bus.out_ready_i = 1'b1;
    #2;
    chk("rst.ready",  bus.data_ready_o, 1);
    chk("rst.val",    bus.out_val_o,    0);
    chk("rst.onehot", bus.onehot_o,     0);
    chk("rst.idx",    bus.idx_o,        0);
    chk("rst.empty",  bus.empty_o,      0);
    chk("rst.last",   bus.last_o,       0);
`ifdef PRIORITY_ENCODER_STREAM_CNT_EN
    chk("rst.cnt",    bus.cnt_o,        0);
`endif
    #10 arst_n = 1'b1;
    step();

    // 0x8421 MSB-first
    bus.data_i = 16'h8421; bus.dir_i = 1'b1; bus.data_val_i = 1'b1;
    step();
    bus.data_val_i = 1'b0;
    beat("msb0", 15, 0, 0); step();
    beat("msb1", 10, 0, 0); step();
    beat("msb2", 5,  0, 0); step();
    beat("msb3", 0,  1, 1); step();
    chk("msb.idle", bus.out_val_o, 0);

    // 0x8421 LSB-first
    bus.data_i = 16'h8421; bus.dir_i = 1'b0; bus.data_val_i = 1'b1;
    step();
    bus.data_val_i = 1'b0;
    beat("lsb0", 0, 0, 0);
`ifdef PRIORITY_ENCODER_STREAM_CNT_EN
    chk("lsb0.cnt", bus.cnt_o, 4);
`endif
    step();
    beat("lsb1", 5, 0, 0);
`ifdef PRIORITY_ENCODER_STREAM_CNT_EN
    chk("lsb1.cnt", bus.cnt_o, 3);
`endif
    step();
    beat("lsb2", 10, 0, 0);
`ifdef PRIORITY_ENCODER_STREAM_CNT_EN
    chk("lsb2.cnt", bus.cnt_o, 2);
`endif
    step();
    beat("lsb3", 15, 1, 1);
`ifdef PRIORITY_ENCODER_STREAM_CNT_EN
    chk("lsb3.cnt", bus.cnt_o, 1);
`endif
    step();
    chk("lsb.idle", bus.out_val_o, 0);
`ifdef PRIORITY_ENCODER_STREAM_CNT_EN
    chk("lsb.idle.cnt", bus.cnt_o, 0);
`endif

    // empty word
    bus.data_i = 16'h0000; bus.dir_i = 1'b1; bus.data_val_i = 1'b1;
    step();
    bus.data_val_i = 1'b0;
    chk("emp.val",    bus.out_val_o,    1);
    chk("emp.onehot", bus.onehot_o,     0);
    chk("emp.idx",    bus.idx_o,        0);
    chk("emp.empty",  bus.empty_o,      1);
    chk("emp.last",   bus.last_o,       1);
    chk("emp.ready",  bus.data_ready_o, 1);
`ifdef PRIORITY_ENCODER_STREAM_CNT_EN
    chk("emp.cnt",    bus.cnt_o,        0);
`endif
    step();
    chk("emp.idle", bus.out_val_o, 0);

    // back-to-back words with the second held valid
    bus.data_i = 16'h0003; bus.dir_i = 1'b0; bus.data_val_i = 1'b1;
    step();
    bus.data_i = 16'h8000; bus.dir_i = 1'b1;
    beat("b2b0", 0, 0, 0); step();
    beat("b2b1", 1, 1, 1); step();
    bus.data_val_i = 1'b0;
    beat("b2b2", 15, 1, 1); step();
    chk("b2b.idle", bus.out_val_o, 0);

    // backpressure on the first beat
    bus.data_i = 16'h00F0; bus.dir_i = 1'b1; bus.data_val_i = 1'b1;
    step();
    bus.data_val_i = 1'b0;
    bus.out_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      beat($sformatf("bp.hold%0d", c), 7, 0, 0);
      step();
    end
    bus.out_ready_i = 1'b1;
    beat("bp7", 7, 0, 0); step();
    beat("bp6", 6, 0, 0); step();
    beat("bp5", 5, 0, 0); step();
    beat("bp4", 4, 1, 1); step();
    chk("bp.idle", bus.out_val_o, 0);

    // asynchronous reset in the middle of 0xFFFF
    bus.data_i = 16'hFFFF; bus.dir_i = 1'b1; bus.data_val_i = 1'b1;
    step();
    bus.data_val_i = 1'b0;
    beat("mr0", 15, 0, 0); step();
    beat("mr1", 14, 0, 0);
    #3 arst_n = 1'b0;
    #1;
    chk("mr.val",    bus.out_val_o,    0);
    chk("mr.ready",  bus.data_ready_o, 1);
    chk("mr.onehot", bus.onehot_o,     0);
    @(negedge clk);
    arst_n = 1'b1;
    bus.data_i = 16'h0001; bus.dir_i = 1'b0; bus.data_val_i = 1'b1;
    #1;
    chk("mr.idle.ready", bus.data_ready_o, 1);
    step();
    bus.data_val_i = 1'b0;
    beat("mr.new", 0, 1, 1); step();
    chk("mr.end", bus.out_val_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
